// File: rtl/tennis_pkg.sv
// Shared types for the LED tennis engine: FSM state encoding and player indices.
package tennis_pkg;

  typedef enum logic [2:0] {
    SERVE_1 = 3'd0,
    SERVE_2 = 3'd1,
    MOVE_DN = 3'd2,
    MOVE_UP = 3'd3,
    POINT   = 3'd4,
    OVER    = 3'd5
  } tennis_state_t;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

endpackage

// File: rtl/rally_tick_timer.sv
// Loadable step timer: counts period-1 down to 0, flags a tick at 0 and reloads.
module rally_tick_timer #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = (r_cnt == '0);

  // Reload on an explicit load or on expiry so the next step is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load || o_tick) begin
      r_cnt <= i_period - DIV_W'(1);
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/tennis_rally.sv
// Two-player LED tennis engine: ball movement, hit windows, speed-up, scoring,
// point flash, loser-serves and game-over. All outputs are registered.
module tennis_rally
  import tennis_pkg::*;
#(
  parameter int N_LEDS       = 16,
  parameter int TICK_DIV     = 50_000_000,
  parameter int MIN_DIV      = 5_000_000,
  parameter int SPEEDUP      = 5_000_000,
  parameter int HIT_WINDOW   = 2,
  parameter int WIN_SCORE    = 7,
  parameter int FLASH_CYCLES = 25_000_000,
  localparam int SCORE_W     = $clog2(WIN_SCORE + 1)
) (
  input  logic               clk,
  input  logic               reset_clk,
  input  logic               but_1,
  input  logic               but_2,
  output logic [N_LEDS-1:0]  led,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic               game_over
);

  localparam int DIV_W   = $clog2(TICK_DIV + 1);
  localparam int POS_W   = $clog2(N_LEDS);
  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

  localparam logic [POS_W-1:0]   POS_TOP   = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0]   HIT_LO    = POS_W'(HIT_WINDOW);
  localparam logic [POS_W-1:0]   HIT_HI    = POS_W'(N_LEDS - HIT_WINDOW);
  localparam logic [DIV_W-1:0]   DIV_SERVE = DIV_W'(TICK_DIV);
  localparam logic [DIV_W-1:0]   DIV_MIN   = DIV_W'(MIN_DIV);
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
  localparam logic [FLASH_W-1:0] FLASH_TOP = FLASH_W'(FLASH_CYCLES - 1);

  // Shorten the step period, comparing first so the subtraction can never wrap.
  function automatic logic [DIV_W-1:0] speed_up(input logic [DIV_W-1:0] div);
    logic [31:0] d;
    d = 32'(div);
    if (d < 32'(MIN_DIV) + 32'(SPEEDUP)) begin
      speed_up = DIV_MIN;
    end else begin
      speed_up = DIV_W'(d - 32'(SPEEDUP));
    end
  endfunction

  tennis_state_t      r_state;
  tennis_state_t      w_state_nxt;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   w_pos_nxt;
  logic [DIV_W-1:0]   r_cur_div;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [FLASH_W-1:0] r_flash;
  logic [SCORE_W-1:0] r_score_1;
  logic [SCORE_W-1:0] r_score_2;
  logic               r_win;
  logic               r_game_over;
  logic [N_LEDS-1:0]  r_led;
  logic [N_LEDS-1:0]  w_led_nxt;
  logic               r_but_1_q;
  logic               r_but_2_q;
  logic               w_press_1;
  logic               w_press_2;
  logic               w_tick;
  logic               w_load;
  logic               w_pt_1;
  logic               w_pt_2;

  assign w_press_1 = but_1 & ~r_but_1_q;
  assign w_press_2 = but_2 & ~r_but_2_q;

  rally_tick_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset_clk),
    .i_load   (w_load),
    .i_period (w_div_nxt),
    .o_tick   (w_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_clk) begin
    if (!reset_clk) begin
      r_state <= SERVE_1;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a press is evaluated before the tick, so a coincident tick is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_div_nxt   = r_cur_div;
    w_load      = 1'b0;
    w_pt_1      = 1'b0;
    w_pt_2      = 1'b0;
    case (r_state)
      SERVE_1: begin
        w_pos_nxt = POS_TOP;
        if (w_press_1) begin
          w_state_nxt = MOVE_DN;
          w_load      = 1'b1;
        end
      end
      SERVE_2: begin
        w_pos_nxt = '0;
        if (w_press_2) begin
          w_state_nxt = MOVE_UP;
          w_load      = 1'b1;
        end
      end
      MOVE_DN: begin
        if (w_press_2) begin
          if (r_pos < HIT_LO) begin
            w_state_nxt = MOVE_UP;
            w_div_nxt   = speed_up(r_cur_div);
            w_load      = 1'b1;
          end else begin
            w_pt_1 = 1'b1;
          end
        end else if (w_tick) begin
          if (r_pos == '0) begin
            w_pt_1 = 1'b1;
          end else begin
            w_pos_nxt = r_pos - POS_W'(1);
          end
        end
      end
      MOVE_UP: begin
        if (w_press_1) begin
          if (r_pos >= HIT_HI) begin
            w_state_nxt = MOVE_DN;
            w_div_nxt   = speed_up(r_cur_div);
            w_load      = 1'b1;
          end else begin
            w_pt_2 = 1'b1;
          end
        end else if (w_tick) begin
          if (r_pos == POS_TOP) begin
            w_pt_2 = 1'b1;
          end else begin
            w_pos_nxt = r_pos + POS_W'(1);
          end
        end
      end
      POINT: begin
        if (r_flash == '0) begin
          if (r_score_1 == SCORE_WIN || r_score_2 == SCORE_WIN) begin
            w_state_nxt = OVER;
          end else if (r_win == PLAYER_1) begin
            w_state_nxt = SERVE_2;
            w_pos_nxt   = '0;
            w_div_nxt   = DIV_SERVE;
          end else begin
            w_state_nxt = SERVE_1;
            w_pos_nxt   = POS_TOP;
            w_div_nxt   = DIV_SERVE;
          end
        end
      end
      OVER: begin
        w_state_nxt = OVER;
      end
      default: begin
        w_state_nxt = SERVE_1;
        w_pos_nxt   = POS_TOP;
      end
    endcase
    if (w_pt_1 || w_pt_2) begin
      w_state_nxt = POINT;
    end
  end

  // Output decode: LED pattern that the bar shows after the coming edge.
  always_comb begin
    w_led_nxt = '0;
    case (w_state_nxt)
      POINT: w_led_nxt = '1;
      OVER: begin
        for (int i = 0; i < N_LEDS; i++) begin
          if (r_win == PLAYER_1) begin
            w_led_nxt[i] = (i >= N_LEDS - N_LEDS / 2);
          end else begin
            w_led_nxt[i] = (i < N_LEDS / 2);
          end
        end
      end
      default: w_led_nxt[w_pos_nxt] = 1'b1;
    endcase
  end

  // Rally datapath: ball position, speed, flash timer, scores and registered outputs.
  always_ff @(posedge clk or negedge reset_clk) begin
    if (!reset_clk) begin
      r_pos       <= POS_TOP;
      r_cur_div   <= DIV_SERVE;
      r_flash     <= '0;
      r_score_1   <= '0;
      r_score_2   <= '0;
      r_win       <= PLAYER_1;
      r_game_over <= 1'b0;
      r_led       <= {1'b1, {(N_LEDS-1){1'b0}}};
      r_but_1_q   <= 1'b0;
      r_but_2_q   <= 1'b0;
    end else begin
      r_but_1_q   <= but_1;
      r_but_2_q   <= but_2;
      r_pos       <= w_pos_nxt;
      r_cur_div   <= w_div_nxt;
      r_led       <= w_led_nxt;
      r_game_over <= (w_state_nxt == OVER);
      if (w_pt_1 || w_pt_2) begin
        r_flash <= FLASH_TOP;
        r_win   <= w_pt_1 ? PLAYER_1 : PLAYER_2;
      end else if (r_state == POINT && r_flash != '0) begin
        r_flash <= r_flash - FLASH_W'(1);
      end
      if (w_pt_1 && r_score_1 != SCORE_WIN) begin
        r_score_1 <= r_score_1 + SCORE_W'(1);
      end
      if (w_pt_2 && r_score_2 != SCORE_WIN) begin
        r_score_2 <= r_score_2 + SCORE_W'(1);
      end
    end
  end

  assign led       = r_led;
  assign score_1   = r_score_1;
  assign score_2   = r_score_2;
  assign game_over = r_game_over;

endmodule

// File: doc/tennis_rally.md
# tennis_rally

Parametrised two-player LED tennis engine: a lit LED (the ball) walks across an N-LED bar at a programmable step rate, and each player returns it with a button press inside a hit window at their end. Adds what the fixed 16-LED ball mover lacked: configurable bar width, per-return speed-up, early-swing faults, scoring, point flash, loser-serves and game-over. Sits between the debounced board buttons and the LED bar / score display.

## Interface
- N_LEDS, 16: bar width, ≥4
- TICK_DIV, 50_000_000: clock cycles per ball step at serve speed, ≥2
- MIN_DIV, 5_000_000: fastest step period in cycles, 2 ≤ MIN_DIV ≤ TICK_DIV
- SPEEDUP, 5_000_000: cycles removed from the step period per successful return
- HIT_WINDOW, 2: LEDs at each end where a press counts as a hit, 1 ≤ HIT_WINDOW < N_LEDS/2
- WIN_SCORE, 7: points needed to win
- FLASH_CYCLES, 25_000_000: length of the point flash in cycles
- clk  in  1  system clock
- reset_clk  in  1  asynchronous, active-low reset
- but_1  in  1  player 1 button, debounced and synchronous to clk; player 1 owns led[N_LEDS-1]
- but_2  in  1  player 2 button, same conditioning; player 2 owns led[0]
- led  out  N_LEDS  bar drive
- score_1  out  SCORE_W  player 1 points, SCORE_W = $clog2(WIN_SCORE+1)
- score_2  out  SCORE_W  player 2 points
- game_over  out  1  high once either score reaches WIN_SCORE

## Operation
- Press = rising edge: but_x high while its registered copy is low. Held buttons produce one press.
- States: SERVE_1, SERVE_2, MOVE_DN (toward player 2), MOVE_UP (toward player 1), POINT, OVER.
- Reset: SERVE_1, pos = N_LEDS-1, cur_div = TICK_DIV, scores 0, game_over 0, led = one-hot(N_LEDS-1).
- SERVE_1: ball parked at N_LEDS-1; but_1 press → MOVE_DN, timer loaded with TICK_DIV. SERVE_2 mirrors: pos 0, but_2 → MOVE_UP. The non-serving player's presses are ignored.
- MOVE_DN, on each tick: if pos == 0, the ball is out → point to player 1; otherwise pos decrements.
- MOVE_DN, but_2 press: pos < HIT_WINDOW → hit: MOVE_UP, cur_div = max(cur_div − SPEEDUP, MIN_DIV), timer reloaded. pos ≥ HIT_WINDOW → early swing → point to player 1.
- MOVE_UP mirrors MOVE_DN, with the pos == N_LEDS-1 boundary, but_1 and player 2 scoring.
- During MOVE_x the striking player's presses are ignored.
- Point: the winner's score increments, then POINT with all LEDs lit for FLASH_CYCLES cycles.
- After the flash, if neither score equals WIN_SCORE: the point loser serves (SERVE_1 or SERVE_2), ball parked at the loser's end, cur_div reset to TICK_DIV.
- If a score equals WIN_SCORE: OVER, game_over = 1, led shows the winner's half lit (upper N_LEDS/2 for player 1, lower for player 2). OVER holds until reset; buttons are ignored.
- led outside POINT and OVER: one-hot(pos).
- Scores never exceed WIN_SCORE.
- Speed arithmetic: compare before subtracting (cur_div − SPEEDUP < MIN_DIV → MIN_DIV), so it never underflows. Width DIV_W = $clog2(TICK_DIV+1).

## Timing
- All outputs are registered. A press sampled at edge k changes state/led after edge k; there is no extra sync latency.
- Step timer: loaded with cur_div−1, decrements each cycle, ticks at 0 and reloads. The first step after a serve or hit comes exactly cur_div cycles after the transition.
- Press and tick in the same cycle: the press wins. The hit/fault is evaluated at the current pos and that tick is discarded.
- Both buttons in the same cycle: each is evaluated independently per the state rules. Only the receiving player's press has effect.
- Reset asserted mid-rally or mid-flash: all outputs return to reset values immediately (asynchronous). Reset release is safe on any edge.

## Structure
- tennis_pkg: state enum (tennis_state_t) and player index constants.
- Sub-module rally_tick_timer: loadable down-counter with load and period inputs and a tick output, parametrised by DIV_W.
- The FSM, speed register, scores and LED decode live in tennis_rally.

## Test plan
Bench parameters: N_LEDS=16, TICK_DIV=4, MIN_DIV=2, SPEEDUP=1, HIT_WINDOW=2, WIN_SCORE=3, FLASH_CYCLES=8.
- Reset, idle 20 cycles → led=16'h8000, scores 0, game_over 0; held but_2 has no effect.
- but_1 pulse, no return → led walks 8000→4000→…→0001 one step per 4 cycles; the next tick gives score_1=1, 8 cycles of FFFF, then SERVE_2 with led=0001.
- Serve, but_2 press at led=0002 → ball reverses; steps now every 3 cycles. Three more returns → period floors at 2.
- but_2 press at led=0010 (pos 4) → early swing: score_1 increments immediately, then flash.
- Press landing on the same cycle as the tick at pos 0 → counted as a hit, no point awarded.
- Player 1 wins three points → game_over=1, led=FF00 held; presses ignored; reset_clk low mid-flash in another run → instant return to 8000 with scores 0.
